// File: rtl/ctrl_uart_tx.sv
// Framing UART transmitter: accepts one 16-bit word per frame and sends it
// as four 8N1 bytes (sync, high, low, xor checksum) on a single tx line.
module ctrl_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   output logic        in_rdy,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        tx,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] baud_cnt;
   logic [1:0]       byte_idx;
   logic [2:0]       bit_idx;
   logic [15:0]      word;
   logic [7:0]       checksum;
   logic [7:0]       cur_byte;
   logic             bit_done;

   assign bit_done = (baud_cnt == BAUD_LAST);

   // NOTE: always_comb assigns cur_byte on every path so no latch is inferred.
   always_comb begin
      cur_byte = SYNC_BYTE;
      case (byte_idx)
         2'd1:    cur_byte = word[15:8];
         2'd2:    cur_byte = word[7:0];
         2'd3:    cur_byte = checksum;
         default: cur_byte = SYNC_BYTE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         byte_idx  <= '0;
         bit_idx   <= '0;
         word      <= '0;
         checksum  <= '0;
         in_rdy    <= 1'b0;
         busy      <= 1'b0;
         tx        <= 1'b1;
         frame_cnt <= '0;
      end else if (state == S_IDLE) begin
         baud_cnt <= '0;
         if (in_rdy && in_valid) begin
            word     <= in_data;
            checksum <= in_data[15:8] ^ in_data[7:0];
            byte_idx <= '0;
            state    <= S_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            in_rdy   <= 1'b0;
         end else begin
            in_rdy <= 1'b1;
            busy   <= 1'b0;
            tx     <= 1'b1;
         end
      end else if (!bit_done) begin
         baud_cnt <= baud_cnt + 1'b1;
      end else begin
         // Bit time elapsed: restart the baud count and present the next bit.
         baud_cnt <= '0;
         case (state)
            S_START: begin
               state   <= S_DATA;
               bit_idx <= '0;
               tx      <= cur_byte[0];
            end
            S_DATA: begin
               if (bit_idx == 3'd7) begin
                  state <= S_STOP;
                  tx    <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  tx      <= cur_byte[bit_idx + 3'd1];
               end
            end
            default: begin
               if (byte_idx != 2'd3) begin
                  byte_idx <= byte_idx + 2'd1;
                  state    <= S_START;
                  tx       <= 1'b0;
               end else begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  in_rdy    <= 1'b1;
                  frame_cnt <= frame_cnt + 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_uart_tx.sv
// Bench for ctrl_uart_tx: a frame-level timing model is compared every cycle,
// and directed frames are decoded from tx and checked against literal bytes.
module tb_ctrl_uart_tx;

   localparam int C = 4;
   localparam int FRAME = 40 * C;

   logic        clk;
   logic        rst;
   logic        in_rdy;
   logic        in_valid;
   logic [15:0] in_data;
   logic        tx;
   logic        busy;
   logic [15:0] frame_cnt;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   ctrl_uart_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_rdy    (in_rdy),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .tx        (tx),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: a frame occupies FRAME cycles after the accept edge.
   bit          m_act  = 1'b0;
   bit          m_rdy  = 1'b0;
   int          m_el   = 0;
   logic [15:0] m_word = '0;
   logic [15:0] m_cnt  = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act = 1'b0;
         m_rdy = 1'b0;
         m_el  = 0;
         m_cnt = '0;
      end else begin
         if (m_act) begin
            m_el++;
            if (m_el == FRAME) begin
               m_act = 1'b0;
               m_cnt = m_cnt + 16'd1;
            end
         end else if (m_rdy && in_valid) begin
            m_act  = 1'b1;
            m_el   = 0;
            m_word = in_data;
         end
         m_rdy = !m_act;
      end
   end

   function automatic logic exp_tx();
      logic [7:0] fb [4];
      int b, k, p;
      if (!m_act) return 1'b1;
      fb[0] = 8'hA5;
      fb[1] = m_word[15:8];
      fb[2] = m_word[7:0];
      fb[3] = m_word[15:8] ^ m_word[7:0];
      b = m_el / C;
      k = b / 10;
      p = b % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return fb[k][p-1];
   endfunction

   always @(negedge clk) begin
      check("tx", {31'd0, tx}, {31'd0, exp_tx()});
      check("busy", {31'd0, busy}, {31'd0, m_act});
      check("in_rdy", {31'd0, in_rdy}, {31'd0, m_rdy});
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
   end

   // Waits for in_rdy at a falling edge, then offers one word for one cycle.
   // Returns at the falling edge right after the accept edge.
   task automatic send(input logic [15:0] w);
      int n = 0;
      while (in_rdy !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("send_rdy_timeout", {31'd0, in_rdy}, 32'd1);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Samples 40 bit times from the first low tx, 1.5 cycles into each bit.
   task automatic recv_frame(output logic [31:0] got, output logic frm_ok);
      logic bits [40];
      int n = 0;
      got    = '0;
      frm_ok = 1'b0;
      while (tx !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         check("rx_start_timeout", 32'd1, 32'd0);
         return;
      end
      @(negedge clk);
      for (int j = 0; j < 40; j++) begin
         bits[j] = tx;
         if (j < 39) repeat (C) @(negedge clk);
      end
      frm_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (bits[10*k] !== 1'b0 || bits[10*k+9] !== 1'b1) frm_ok = 1'b0;
         for (int i = 0; i < 8; i++) got[(3-k)*8 + i] = bits[10*k + 1 + i];
      end
   endtask

   task automatic count_rdy_low(output int nlow);
      nlow = 0;
      while (in_rdy === 1'b0 && nlow < 1000) begin
         nlow++;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(busy === 1'b0 && in_rdy === 1'b1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, (n < 1000)}, 32'd1);
   endtask

   logic [31:0] got;
   logic        ok;
   int          nlow;
   logic [15:0] base;
   logic [15:0] q [$];
   int          xt [$];
   bit          pend;

   initial begin
      in_valid = 1'b0;
      in_data  = '0;
      rst      = 1'b0;
      #1 rst   = 1'b1;

      // Reset idle
      repeat (3) @(negedge clk);
      check("rdy_in_reset", {31'd0, in_rdy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rdy_after_release", {31'd0, in_rdy}, 32'd1);
      repeat (50) @(negedge clk);
      check("idle_tx", {31'd0, tx}, 32'd1);
      check("idle_cnt", {16'd0, frame_cnt}, 32'd0);

      // Single frame
      send(16'h1234);
      fork
         recv_frame(got, ok);
         count_rdy_low(nlow);
      join
      check("single_bytes", got, 32'hA512_3426);
      check("single_framing", {31'd0, ok}, 32'd1);
      check("single_rdy_low", nlow, FRAME);
      check("single_cnt", {16'd0, frame_cnt}, 32'd1);

      // Checksum edges
      send(16'hFFFF);
      recv_frame(got, ok);
      check("ffff_bytes", got, 32'hA5FF_FF00);
      check("ffff_framing", {31'd0, ok}, 32'd1);
      wait_idle();
      send(16'h0000);
      recv_frame(got, ok);
      check("zero_bytes", got, 32'hA500_0000);
      check("zero_framing", {31'd0, ok}, 32'd1);
      wait_idle();

      // Back-to-back from an upstream buffer holding valid
      base = frame_cnt;
      for (int i = 0; i < 10; i++) q.push_back(16'h0014 + 16'(i));
      pend = 1'b0;
      for (int n = 0; n < 3000 && q.size() > 0; n++) begin
         @(negedge clk);
         if (pend) begin
            void'(q.pop_front());
            xt.push_back(cyc);
         end
         if (q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = q[0];
         end else begin
            in_valid = 1'b0;
         end
         pend = in_valid && in_rdy;
      end
      in_valid = 1'b0;
      check("b2b_buffer_empty", q.size(), 32'd0);
      check("b2b_transfers", xt.size(), 32'd10);
      for (int i = 1; i < xt.size(); i++) check("b2b_spacing", xt[i] - xt[i-1], FRAME + 1);
      wait_idle();
      check("b2b_cnt", {16'd0, frame_cnt - base}, 32'd10);

      // Ignored valid while busy
      base = frame_cnt;
      send(16'h0102);
      repeat (20) @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      repeat (200) @(negedge clk);
      check("ignored_cnt", {16'd0, frame_cnt - base}, 32'd1);
      check("ignored_busy", {31'd0, busy}, 32'd0);

      // Reset during DATA of byte 2
      send(16'h5A3C);
      repeat (92) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
      check("rst_rdy", {31'd0, in_rdy}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_tx", {31'd0, tx}, 32'd1);
      send(16'hC3A5);
      recv_frame(got, ok);
      check("post_rst_bytes", got, 32'hA5C3_A566);
      check("post_rst_framing", {31'd0, ok}, 32'd1);
      wait_idle();
      check("post_rst_cnt", {16'd0, frame_cnt}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ctrl_uart_tx.md
# ctrl_uart_tx

Framing UART transmitter that sits directly downstream of the buffer's controller-side output (`ctrl_out_*`). It pops 16-bit words over a ready/valid handshake, wraps each word in a 4-byte frame (sync, high byte, low byte, checksum) and shifts the frame out as 8N1 serial on a single `tx` line to the motor-controller board. One word is accepted per frame; the block stalls the buffer by holding `in_rdy` low while a frame is on the wire.

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per UART bit (868 = 115200 baud at 100 MHz); legal range ≥ 2.
- `SYNC_BYTE`, 8'hA5, first byte of every frame.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_rdy`  out  1  block can accept a word this cycle; drives the buffer's `ctrl_out_rdy`.
- `in_valid`  in  1  `in_data` holds a valid word; driven by the buffer's `ctrl_out_valid`.
- `in_data`  in  16  word to transmit; driven by the buffer's `ctrl_out_data`.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high while a frame is being shifted out.
- `frame_cnt`  out  16  count of fully transmitted frames; wraps modulo 2^16.

## Operation
- **Handshake.** A word transfers on the rising edge where `in_rdy && in_valid`.
  - `in_data` is latched on that edge.
  - Nothing else is sampled outside a transfer edge.
- **Frame contents**, in order: `SYNC_BYTE`, `in_data[15:8]`, `in_data[7:0]`, `in_data[15:8] ^ in_data[7:0]`.
- **Byte format:** start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- **State machine:** IDLE, START, DATA, STOP, plus a 2-bit byte index (0–3) and a 3-bit bit index.
  - IDLE: `in_rdy`=1, `busy`=0, `tx`=1. On transfer, latch the word, compute the checksum, set byte index to 0, go to START.
  - START: `tx`=0 for one bit time, then go to DATA with bit index 0.
  - DATA: `tx` = current byte[bit index] for one bit time. After bit 7, go to STOP.
  - STOP: `tx`=1 for one bit time.
    - If byte index < 3: increment byte index and go to START.
    - Otherwise: increment `frame_cnt` and go to IDLE.
- **Outputs.** `in_rdy`, `busy` and `tx` are registered outputs. `in_rdy` is 0 in every state except IDLE.
- **Baud counter.** Width is `$clog2(CLKS_PER_BIT)`. It reloads to 0 on every state or bit change and never free-runs in IDLE.
- **`in_valid` while not ready.** `in_valid` high while `in_rdy`=0 is ignored; the upstream buffer holds the word.
- **`frame_cnt` wrap.** `frame_cnt` wraps from 16'hFFFF to 16'h0000 with no flag.
- **Reset mid-frame.** On `rst` assertion the following happen immediately (asynchronously):
  - `tx` goes to 1 and `busy` to 0.
  - The partial frame and latched word are discarded.
  - `frame_cnt` clears.
  - No partial frame resumes after reset.

## Timing
- **Reset values:** `in_rdy`=0, `busy`=0, `tx`=1, `frame_cnt`=0, state=IDLE.
- **After reset release:** `in_rdy` rises at the first rising edge after `rst` deasserts.
- **Transfer edge T:** `tx` falls (start bit of the sync byte) and `busy` rises at edge T, so both are visible in the cycle after the accept. `in_rdy` falls at edge T.
- **Frame length:** 40 × `CLKS_PER_BIT` cycles, measured from edge T to the end of the last stop bit.
- **Frame end:** at edge T + 40×`CLKS_PER_BIT`:
  - `in_rdy` returns to 1 and `busy` to 0.
  - `frame_cnt` increments, visible the same cycle `in_rdy` rises.
- **Back-to-back words.** With `in_valid` held high, the next transfer occurs one cycle after `in_rdy` rises. Frame-to-frame period is 40×`CLKS_PER_BIT` + 1 cycles, with 1 extra idle-high cycle between frames.
- **Latency:** 1 cycle from transfer to the first `tx` transition. No combinational path exists from `in_valid` to `in_rdy`.

## Test plan
- **Reset idle.** `CLKS_PER_BIT`=4; hold `rst` for 3 cycles, then release with `in_valid`=0 for 50 cycles.
  - Required: `tx`=1, `busy`=0 and `frame_cnt`=0 throughout; `in_rdy`=1 from the first edge after release.
- **Single frame.** Send word 16'h1234.
  - Required: `tx`, sampled mid-bit, decodes to bytes A5, 12, 34, 26 with correct start/stop bits.
  - Required: `in_rdy`=0 for exactly 160 cycles; `frame_cnt`=1 afterwards.
- **Checksum edge.** Send word 16'hFFFF; required bytes: A5, FF, FF, 00. Then send 16'h0000; required bytes: A5, 00, 00, 00.
- **Back-to-back from buffer.** Connect `bc_buffer`, push 10 words 16'h0014..16'h001D, and hold `ctrl_out` valid.
  - Required: 10 frames in order with 161-cycle spacing; `frame_cnt`=10; buffer empty at the end.
- **Reset mid-frame.** Assert `rst` during the DATA state of byte 2.
  - Required: `tx`=1 within the same cycle and stays high; `frame_cnt`=0; the next word after release produces one complete, correct frame.
- **Ignored valid.** Pulse `in_valid` with 16'hBEEF while `busy`=1, not held to `in_rdy`.
  - Required: no transfer; `frame_cnt` advances only for the original frame.
